// File: rtl/key_event_queue.sv
// PS/2 scan-byte sequencer: folds E0/F0 prefixes into key events, optionally
// suppresses typematic repeats, and queues events in a first-word-fall-through FIFO.
module key_event_queue #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit FILTER_REPEAT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_release,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               err_count,
  output logic [1:0]               parser_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_E0     = 2'd1,
    ST_F0     = 2'd2,
    ST_E0F0   = 2'd3
  } state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } event_t;

  // Keyboard housekeeping bytes (BAT result, ACK, resend, errors) that carry no key.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // ---------------------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            timer_expired;
  logic            parse_push;
  logic            proto_err;
  event_t          parse_ev;
  logic            is_prefix;

  assign is_prefix     = (byte_in == B_EXT) || (byte_in == B_BREAK);
  assign timer_expired = (state_q != ST_IDLE) && !byte_valid && (tmr_q == TMR_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_in == B_EXT)        state_d = ST_E0;
          else if (byte_in == B_BREAK) state_d = ST_F0;
        end
        ST_E0: begin
          if (byte_in == B_BREAK)      state_d = ST_E0F0;
          else if (byte_in != B_EXT)   state_d = ST_IDLE;
        end
        ST_F0, ST_E0F0:                state_d = ST_IDLE;
        default:                       state_d = ST_IDLE;
      endcase
    end else if (timer_expired) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    parse_push = 1'b0;
    proto_err  = 1'b0;
    parse_ev   = '{ext: 1'b0, rel: 1'b0, code: byte_in};
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: parse_push = !is_prefix && !is_noise(byte_in);
        ST_E0: begin
          parse_push   = !is_prefix;
          parse_ev.ext = 1'b1;
        end
        ST_F0: begin
          proto_err    = is_prefix;
          parse_push   = !is_prefix;
          parse_ev.rel = 1'b1;
        end
        ST_E0F0: begin
          proto_err    = is_prefix;
          parse_push   = !is_prefix;
          parse_ev.ext = 1'b1;
          parse_ev.rel = 1'b1;
        end
        default: parse_push = 1'b0;
      endcase
    end
  end

  // The timeout counter only advances while a prefix is pending and no byte arrives.
  always_comb begin
    tmr_d = tmr_q + TW'(1);
    if (state_q == ST_IDLE || byte_valid || timer_expired) tmr_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Typematic repeat filter
  // ---------------------------------------------------------------------------
  logic       rec_valid_q, rec_valid_d;
  logic       rec_ext_q,   rec_ext_d;
  logic [7:0] rec_code_q,  rec_code_d;
  logic       rec_match;
  logic       push_req;

  assign rec_match = rec_valid_q && (rec_ext_q == parse_ev.ext) &&
                     (rec_code_q == parse_ev.code);
  assign push_req  = parse_push &&
                     !(FILTER_REPEAT && !parse_ev.rel && rec_match);

  always_comb begin
    rec_valid_d = rec_valid_q;
    rec_ext_d   = rec_ext_q;
    rec_code_d  = rec_code_q;
    if (FILTER_REPEAT && parse_push) begin
      if (!parse_ev.rel && !rec_match) begin
        rec_valid_d = 1'b1;
        rec_ext_d   = parse_ev.ext;
        rec_code_d  = parse_ev.code;
      end else if (parse_ev.rel && rec_match) begin
        rec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_valid_q <= 1'b0;
      rec_ext_q   <= 1'b0;
      rec_code_q  <= '0;
    end else begin
      rec_valid_q <= rec_valid_d;
      rec_ext_q   <= rec_ext_d;
      rec_code_q  <= rec_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO with a registered head so empty-state outputs hold their last value
  // ---------------------------------------------------------------------------
  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_next;
  logic [CW-1:0]   count_q, count_d;
  event_t          head_q, head_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      err_q, err_d;
  logic            do_pop, do_push, ovf_set, err_inc;

  assign do_pop  = (count_q != '0) && ev_ready;
  assign do_push = push_req && ((count_q != CNT_FULL) || do_pop);
  assign ovf_set = push_req && (count_q == CNT_FULL) && !do_pop;
  assign err_inc = proto_err || timer_expired;
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_next           : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    head_d = head_q;
    if (do_pop) begin
      if (count_q == CW'(1)) begin
        if (do_push) head_d = parse_ev;
      end else begin
        head_d = mem[rd_next];
      end
    end else if (count_q == '0 && do_push) begin
      head_d = parse_ev;
    end

    overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    err_d      = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // NOTE: the storage array has no reset; it is never read before being
  // written, and the reset-cleared head register covers the visible outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= parse_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign ev_valid     = (count_q != '0);
  assign ev_code      = head_q.code;
  assign ev_ext       = head_q.ext;
  assign ev_release   = head_q.rel;
  assign ev_count     = count_q;
  assign overflow     = overflow_q;
  assign err_count    = err_q;
  assign parser_state = state_q;

endmodule
